// File: rtl/fp_pack_pkg.sv
// Package fp_pack_pkg
// Shared types and helpers for the subnormal/exponent packer.
//   pack_state_e : packer FSM states (IDLE, SHIFT, DONE)
//   EXPO_MAX(w)  : all-ones exponent field value (inf/NaN code) for a w-bit field
//   CNT_SAT(w)   : shift-count ceiling for a w-bit mantissa field; beyond this
//                  every input bit already sits in guard/sticky
package fp_pack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } pack_state_e;

    function automatic int EXPO_MAX(input int expo_w);
        return (1 << expo_w) - 1;
    endfunction

    function automatic int CNT_SAT(input int mant_w);
        return mant_w + 2;
    endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Module fp_rne_round
// Combinational rounding of a right-shifted mantissa.
// Build option: SUBNORM_PACK_RNE_EN
//   defined   : round-to-nearest-even on {lsb, guard, sticky}
//   undefined : pass-through (truncate toward zero)
// Ports:
//   mant     in  MANT_W+1  shifted mantissa incl. hidden-bit position
//   guard    in  1         first bit shifted out
//   sticky   in  1         OR of all bits shifted out after guard
//   mant_rnd out MANT_W+1  rounded mantissa
//   carry    out 1         rounding reached the hidden-bit position
module fp_rne_round #(
    parameter int MANT_W = 23
) (
    input  logic [MANT_W:0] mant,
    input  logic            guard,
    input  logic            sticky,
    output logic [MANT_W:0] mant_rnd,
    output logic            carry
);

`ifdef SUBNORM_PACK_RNE_EN
    logic inc;
    assign inc      = guard & (sticky | mant[0]);
    // The caller always supplies a mantissa shifted at least once, so its MSB
    // is clear and the increment cannot overflow the vector.
    assign mant_rnd = mant + {{MANT_W{1'b0}}, inc};
`else
    logic unused_rnd;
    assign unused_rnd = guard | sticky;
    assign mant_rnd   = mant;
`endif

    assign carry = mant_rnd[MANT_W];

endmodule

// File: rtl/subnorm_expo_pack.sv
// Module subnorm_expo_pack
// Packs {sign, extended signed exponent, mantissa with hidden bit} into an FP
// word. Normal, zero and overflow inputs pack in one cycle; tiny inputs are
// right-shifted one bit per cycle with guard/sticky tracking, then rounded.
// Build option: SUBNORM_PACK_RNE_EN (round-to-nearest-even, else truncate),
// applied inside fp_rne_round.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_vld / in_rdy   input handshake (in_rdy only in IDLE)
//   ind_sign          sign
//   ind_expo          signed biased exponent, 1 = min normal
//   ind_mant          mantissa with hidden bit as MSB; zero = zero operand
//   out_vld / out_rdy result handshake
//   res               packed {sign, expo, mant}
//   res_uf            tiny before rounding
//   res_inx           nonzero bits were discarded
module subnorm_expo_pack
    import fp_pack_pkg::*;
#(
    parameter  int SIGN_W = 1,
    parameter  int EXPO_W = 8,
    parameter  int MANT_W = 23,
    localparam int FP_W   = SIGN_W + EXPO_W + MANT_W,
    localparam int CNT_W  = $clog2(MANT_W + 3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [SIGN_W-1:0] ind_sign,
    input  logic [EXPO_W+1:0] ind_expo,
    input  logic [MANT_W:0]   ind_mant,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [FP_W-1:0]   res,
    output logic              res_uf,
    output logic              res_inx
);

    localparam int EMAX = EXPO_MAX(EXPO_W);
    localparam int CSAT = CNT_SAT(MANT_W);

    pack_state_e st, st_nx;

    logic [SIGN_W-1:0] sign_q;
    logic [MANT_W:0]   mant_q;
    logic              guard_q, sticky_q;
    logic [CNT_W-1:0]  cnt_q;

    // Input classification
    int                expo_i;
    int                sh_lim;
    logic              is_sub;
    logic [CNT_W-1:0]  sub_cnt;
    logic [EXPO_W-1:0] fast_expo;
    logic [MANT_W-1:0] fast_mant;

    always_comb begin
        expo_i    = int'($signed(ind_expo));
        is_sub    = (ind_mant != '0) && (expo_i <= 0);
        sh_lim    = 1 - expo_i;
        if (sh_lim > CSAT) sh_lim = CSAT;
        sub_cnt   = CNT_W'(sh_lim);
        fast_expo = '0;
        fast_mant = '0;
        if (ind_mant == '0) begin
            fast_expo = '0;
        end else if (expo_i >= EMAX) begin
            fast_expo = '1;
        end else if (expo_i >= 1) begin
            fast_expo = ind_expo[EXPO_W-1:0];
            fast_mant = ind_mant[MANT_W-1:0];
        end
    end

    // One shift step; rounding looks at the post-shift values so the final
    // step can pack in the same cycle.
    logic [MANT_W:0] mant_sh, mant_rnd;
    logic            guard_sh, sticky_sh, rnd_carry, last_shift;

    assign mant_sh    = mant_q >> 1;
    assign guard_sh   = mant_q[0];
    assign sticky_sh  = sticky_q | guard_q;
    assign last_shift = (cnt_q == CNT_W'(1));

    fp_rne_round #(.MANT_W(MANT_W)) u_rnd (
        .mant     (mant_sh),
        .guard    (guard_sh),
        .sticky   (sticky_sh),
        .mant_rnd (mant_rnd),
        .carry    (rnd_carry)
    );

    // FSM
    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx   = st;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (st)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) st_nx = is_sub ? SHIFT : DONE;
            end
            SHIFT: begin
                if (last_shift) st_nx = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                if (out_rdy) st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q   <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            res      <= '0;
            res_uf   <= 1'b0;
            res_inx  <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_vld) begin
                    sign_q   <= ind_sign;
                    mant_q   <= ind_mant;
                    guard_q  <= 1'b0;
                    sticky_q <= 1'b0;
                    cnt_q    <= sub_cnt;
                    res_uf   <= is_sub;
                    res_inx  <= 1'b0;
                    if (!is_sub) res <= {ind_sign, fast_expo, fast_mant};
                end
                SHIFT: begin
                    mant_q   <= mant_sh;
                    guard_q  <= guard_sh;
                    sticky_q <= sticky_sh;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (last_shift) begin
                        // A rounding carry into the hidden bit promotes the
                        // result to the smallest normal.
                        res     <= {sign_q, (rnd_carry ? EXPO_W'(1) : EXPO_W'(0)),
                                    mant_rnd[MANT_W-1:0]};
                        res_inx <= guard_sh | sticky_sh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subnorm_expo_pack.sv
module tb_subnorm_expo_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [0:0]  ind_sign;
    logic [9:0]  ind_expo;
    logic [23:0] ind_mant;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] res;
    logic        res_uf;
    logic        res_inx;

    int checks = 0;
    int errors = 0;

    subnorm_expo_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .ind_sign (ind_sign),
        .ind_expo (ind_expo),
        .ind_mant (ind_mant),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .res      (res),
        .res_uf   (res_uf),
        .res_inx  (res_inx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level packing. A tiny operand is the integer mantissa
    // divided by 2^(1-expo); the quotient, its rounding and the remainder
    // give the result and flags directly.
    function automatic void model(input logic s, input int e, input logic [23:0] m,
                                  output logic [31:0] r, output logic uf,
                                  output logic inx, output int lat);
        logic [63:0] m64, q, rem, half, v;
        logic        up;
        int          sh, sc;
        uf = 1'b0; inx = 1'b0; lat = 1;
        if (m == 24'd0) begin
            r = {s, 31'd0};
        end else if (e >= 255) begin
            r = {s, 8'hFF, 23'd0};
        end else if (e >= 1) begin
            r = {s, e[7:0], m[22:0]};
        end else begin
            sh   = 1 - e;
            lat  = 1 + ((sh > 25) ? 25 : sh);
            sc   = (sh > 40) ? 40 : sh;
            m64  = {40'd0, m};
            q    = m64 >> sc;
            rem  = m64 - (q << sc);
            half = 64'd1 << (sc - 1);
`ifdef SUBNORM_PACK_RNE_EN
            up   = (rem > half) || ((rem == half) && q[0]);
`else
            up   = 1'b0;
`endif
            v    = q + {63'd0, up};
            r    = {s, v[30:0]};
            uf   = 1'b1;
            inx  = (rem != 64'd0);
        end
    endfunction

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!in_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check({tag, "_rdy_timeout"}, {63'd0, in_rdy}, 64'd1);
    endtask

    // Issue one op with out_rdy=1 and check latency/result/flags.
    task automatic run_op(input logic s, input int e, input logic [23:0] m,
                          input string tag, output logic [31:0] got);
        logic [31:0] er;
        logic        euf, einx;
        int          elat, lat;
        model(s, e, m, er, euf, einx, elat);
        wait_rdy(tag);
        in_vld   = 1'b1;
        ind_sign = s;
        ind_expo = e[9:0];
        ind_mant = m;
        @(negedge clk);
        in_vld   = 1'b0;
        lat = 1;
        while (!out_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_vld"}, {63'd0, out_vld}, 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_res"}, {32'd0, res}, {32'd0, er});
        check({tag, "_uf"},  {63'd0, res_uf}, {63'd0, euf});
        check({tag, "_inx"}, {63'd0, res_inx}, {63'd0, einx});
        got = res;
        @(negedge clk);
        check({tag, "_drain"}, {63'd0, out_vld}, 64'd0);
    endtask

    initial begin
        logic [31:0] got, held;
        logic        s;
        int          e, cat;
        logic [23:0] m;

        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        ind_sign = '0; ind_expo = '0; ind_mant = '0;
        repeat (3) @(negedge clk);
        check("rst_in_rdy",  {63'd0, in_rdy}, 64'd1);
        check("rst_out_vld", {63'd0, out_vld}, 64'd0);
        check("rst_res",     {32'd0, res}, 64'd0);
        check("rst_uf",      {63'd0, res_uf}, 64'd0);
        check("rst_inx",     {63'd0, res_inx}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors (binary32)
        run_op(1'b0, 1, 24'h800000, "min_norm", got);
        check("min_norm_const", {32'd0, got}, 64'h00800000);
        run_op(1'b0, 0, 24'h800000, "e0", got);
        check("e0_const", {32'd0, got}, 64'h00400000);
        run_op(1'b0, -22, 24'hC00000, "e_m22", got);
`ifdef SUBNORM_PACK_RNE_EN
        check("e_m22_const", {32'd0, got}, 64'h00000002);
`else
        check("e_m22_const", {32'd0, got}, 64'h00000001);
`endif
        run_op(1'b0, 0, 24'hFFFFFF, "carry", got);
`ifdef SUBNORM_PACK_RNE_EN
        check("carry_const", {32'd0, got}, 64'h00800000);
`else
        check("carry_const", {32'd0, got}, 64'h007FFFFF);
`endif
        run_op(1'b1, -200, 24'h800000, "sat", got);
        check("sat_const", {32'd0, got}, 64'h80000000);
        run_op(1'b0, 255, 24'h800000, "inf", got);
        check("inf_const", {32'd0, got}, 64'h7F800000);
        run_op(1'b0, 100, 24'h000000, "zero", got);
        check("zero_const", {32'd0, got}, 64'h00000000);
        run_op(1'b1, 254, 24'hABCDEF, "max_norm", got);
        run_op(1'b0, -23, 24'hFFFFFF, "e_m23", got);

        // Back-pressure: result held, input ignored while busy
        out_rdy = 1'b0;
        wait_rdy("hold");
        in_vld = 1'b1; ind_sign = 1'b0; ind_expo = 10'h3FB; ind_mant = 24'hA5A5A5; // expo -5
        @(negedge clk);
        ind_expo = 10'd10; ind_mant = 24'h800001;  // must be ignored
        begin
            int n = 0;
            while (!out_vld && n < 40) begin @(negedge clk); n++; end
        end
        check("hold_vld", {63'd0, out_vld}, 64'd1);
        held = res;
        begin
            logic [31:0] er; logic euf, einx; int elat;
            model(1'b0, -5, 24'hA5A5A5, er, euf, einx, elat);
            check("hold_res", {32'd0, held}, {32'd0, er});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stable", {32'd0, res}, {32'd0, held});
            check("hold_in_rdy", {63'd0, in_rdy}, 64'd0);
            check("hold_out_vld", {63'd0, out_vld}, 64'd1);
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check("hold_release", {63'd0, out_vld}, 64'd0);
        check("hold_rdy_next", {63'd0, in_rdy}, 64'd1);

        // Reset in the middle of a subnormal shift
        wait_rdy("mid_rst");
        in_vld = 1'b1; ind_sign = 1'b1; ind_expo = 10'h3EC; ind_mant = 24'hFFFFFF; // expo -20
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", {63'd0, in_rdy}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_vld", {63'd0, out_vld}, 64'd0);
        check("mid_rst_rdy", {63'd0, in_rdy}, 64'd1);
        check("mid_rst_res", {32'd0, res}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, -3, 24'h9ABCDE, "post_rst", got);

        // Randomized ops across all classes
        for (int i = 0; i < 200; i++) begin
            cat = int'($urandom_range(0, 4));
            s   = 1'($urandom);
            m   = 24'($urandom);
            if ($urandom_range(0, 9) == 0) m = 24'd0;
            else if ($urandom_range(0, 1) == 1) m[23] = 1'b1;
            case (cat)
                0: e = int'($urandom_range(0, 27)) - 26;
                1: e = int'($urandom_range(1, 254));
                2: e = int'($urandom_range(255, 511));
                3: e = -int'($urandom_range(27, 512));
                default: e = int'($urandom_range(0, 3)) - 2;
            endcase
            run_op(s, e, m, "rand", got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
